mem2axi_master: RTL and testbench
=================================

MEM2AXI_MASTER -- requirements
Module: mem2axi_master

Interface
REQ-001 Parameters SHALL be: ID_WIDTH, default 1, AXI ID width; AXI_ID, default 0, constant ID driven on AW/AR.
REQ-002 clk  input  1  sole clock; all logic rising-edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 i_req  input  1  native request valid.
REQ-005 i_we  input  1  1 = write, 0 = read.
REQ-006 i_addr  input  32  byte address; bits [2:0] ignored, 64-bit aligned.
REQ-007 i_be  input  8  write byte enables.
REQ-008 i_wdata  input  64  write data.
REQ-009 o_gnt  output  1  request accepted this cycle.
REQ-010 o_rvalid  output  1  one-cycle pulse: read data or write completion.
REQ-011 o_rdata  output  64  read data; valid with o_rvalid on reads.
REQ-012 o_err  output  1  valid with o_rvalid; 1 when bresp/rresp != OKAY.
REQ-013 AXI4 master ports SHALL be, each 1 bit unless a width is given: o_awid[ID_WIDTH], o_awaddr[32], o_awlen[8], o_awsize[3], o_awburst[2], o_awvalid, i_awready; o_wdata[64], o_wstrb[8], o_wlast, o_wvalid, i_wready; i_bid[ID_WIDTH], i_bresp[2], i_bvalid, o_bready; o_arid[ID_WIDTH], o_araddr[32], o_arlen[8], o_arsize[3], o_arburst[2], o_arvalid, i_arready; i_rid[ID_WIDTH], i_rdata[64], i_rresp[2], i_rlast, i_rvalid, o_rready.

Function
REQ-014 Constants: o_awlen = o_arlen = 0; o_awsize = o_arsize = 3; o_awburst = o_arburst = INCR (01); o_wlast = 1; o_awid = o_arid = AXI_ID.
REQ-015 States: IDLE, WR (AW/W pending), WAIT_B, RD (AR pending), WAIT_R.
REQ-016 o_gnt = i_req in IDLE, else 0; on grant, addr (bits [2:0] forced 0), be and wdata SHALL be registered.
REQ-017 IDLE, i_req & i_we -> WR, with o_awvalid = o_wvalid = 1 next cycle; IDLE, i_req & !i_we -> RD, with o_arvalid = 1 next cycle.
REQ-018 In WR, o_awvalid and o_wvalid SHALL each deassert independently the cycle after its own handshake; address, data and strobe SHALL stay stable while valid.
REQ-019 AW and W handshakes in the same or different cycles, in either order, SHALL be accepted; WR -> WAIT_B once both are done.
REQ-020 o_bready = 1 only in WAIT_B; on i_bvalid -> IDLE, with o_rvalid = 1 and o_err = (i_bresp != 0) the next cycle.
REQ-021 RD: o_arvalid held until i_arready, then -> WAIT_R.
REQ-022 o_rready = 1 only in WAIT_R; on i_rvalid, i_rdata and (i_rresp != 0) SHALL be registered -> IDLE, with o_rvalid = 1, o_rdata and o_err the next cycle.
REQ-023 i_bid and i_rid SHALL be ignored; one transaction outstanding at most.
REQ-024 o_rdata SHALL hold its last read value between reads; on a write completion its value is don't-care.
REQ-025 Minimum request-to-o_rvalid latency with zero-wait slave: 3 cycles (grant at T, valid at T+1, response at T+2, o_rvalid at T+3).
REQ-026 A new grant is possible in the cycle o_rvalid is high.

Reset
REQ-027 rst high at a clock edge SHALL force IDLE and clear o_awvalid, o_wvalid, o_arvalid, o_bready, o_rready, o_rvalid and o_err; o_rdata resets to 0.
REQ-028 Reset mid-transaction SHALL abandon that transaction without a completion pulse; o_gnt = 0 while rst is high.

Verification
REQ-029 Write 0x8000_0004, be=0xFF, data=0x1122334455667788, always-ready slave -> awaddr 0x8000_0000, wstrb 0xFF, one o_rvalid with o_err=0 at T+3.
REQ-030 Write with awready delayed 4 cycles and wready immediate -> o_wvalid drops after 1 cycle, o_awvalid held 5 cycles with a stable address, a single completion.
REQ-031 Read with rvalid after 6 wait cycles, rdata=0xDEADBEEFCAFEF00D, rresp=0 -> o_rdata matches, o_rvalid a single pulse, o_err=0.
REQ-032 Read with rresp=SLVERR (10) -> o_rvalid=1 and o_err=1; write with bresp=DECERR (11) -> o_err=1.
REQ-033 Back-to-back requests held with i_req=1 -> second o_gnt in the o_rvalid cycle; never two outstanding valids.
REQ-034 rst asserted while in WAIT_B -> all valids and readies 0 next cycle, no o_rvalid, and a following read completes normally.

Source files
------------

// File: rtl/mem2axi_master.sv
// mem2axi_master
//   Bridges a simple native request/grant memory port onto an AXI4 master
//   using single-beat, 64-bit INCR bursts. At most one transaction is in
//   flight at a time. Writes and reads both complete with a one-cycle
//   o_rvalid pulse; o_err flags a non-OKAY response.
//
// Ports
//   clk, rst              : clock, synchronous active-high reset
//   i_req/i_we/i_addr/i_be/i_wdata : native request (address is 64-bit aligned)
//   o_gnt                 : request accepted this cycle (only in IDLE)
//   o_rvalid/o_rdata/o_err: completion pulse, read data, error flag
//   o_aw*/o_w*/i_b*       : AXI4 write address / data / response channels
//   o_ar*/i_r*            : AXI4 read address / data channels
module mem2axi_master #(
  parameter int                  ID_WIDTH = 1,
  parameter logic [ID_WIDTH-1:0] AXI_ID   = '0
) (
  input  logic                clk,
  input  logic                rst,
  // native side
  input  logic                i_req,
  input  logic                i_we,
  input  logic [31:0]         i_addr,
  input  logic [7:0]          i_be,
  input  logic [63:0]         i_wdata,
  output logic                o_gnt,
  output logic                o_rvalid,
  output logic [63:0]         o_rdata,
  output logic                o_err,
  // AXI write address
  output logic [ID_WIDTH-1:0] o_awid,
  output logic [31:0]         o_awaddr,
  output logic [7:0]          o_awlen,
  output logic [2:0]          o_awsize,
  output logic [1:0]          o_awburst,
  output logic                o_awvalid,
  input  logic                i_awready,
  // AXI write data
  output logic [63:0]         o_wdata,
  output logic [7:0]          o_wstrb,
  output logic                o_wlast,
  output logic                o_wvalid,
  input  logic                i_wready,
  // AXI write response
  input  logic [ID_WIDTH-1:0] i_bid,
  input  logic [1:0]          i_bresp,
  input  logic                i_bvalid,
  output logic                o_bready,
  // AXI read address
  output logic [ID_WIDTH-1:0] o_arid,
  output logic [31:0]         o_araddr,
  output logic [7:0]          o_arlen,
  output logic [2:0]          o_arsize,
  output logic [1:0]          o_arburst,
  output logic                o_arvalid,
  input  logic                i_arready,
  // AXI read data
  input  logic [ID_WIDTH-1:0] i_rid,
  input  logic [63:0]         i_rdata,
  input  logic [1:0]          i_rresp,
  input  logic                i_rlast,
  input  logic                i_rvalid,
  output logic                o_rready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_WAIT_B,
    S_RD,
    S_WAIT_R
  } state_t;

  state_t      r_state;
  logic [28:0] r_addr;   // 64-bit word address; byte offset is always zero
  logic [7:0]  r_be;
  logic [63:0] r_wdata;
  logic        r_awvalid;
  logic        r_wvalid;
  logic        r_arvalid;
  logic        r_bready;
  logic        r_rready;
  logic        r_rvalid;
  logic        r_err;
  logic [63:0] r_rdata;

  // IDs are fixed and only one transaction is outstanding, so response IDs,
  // rlast and the byte offset carry no information.
  logic w_unused;
  assign w_unused = ^{i_bid, i_rid, i_rlast, i_addr[2:0]};

  // A channel counts as done once its valid has dropped, or it is
  // handshaking right now. This lets AW and W finish in any order.
  logic w_aw_done;
  logic w_w_done;
  assign w_aw_done = !r_awvalid || i_awready;
  assign w_w_done  = !r_wvalid  || i_wready;

  assign o_gnt = i_req && (r_state == S_IDLE) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_be      <= '0;
      r_wdata   <= '0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_arvalid <= 1'b0;
      r_bready  <= 1'b0;
      r_rready  <= 1'b0;
      r_rvalid  <= 1'b0;
      r_err     <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_rvalid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_req) begin
            r_addr  <= i_addr[31:3];
            r_be    <= i_be;
            r_wdata <= i_wdata;
            if (i_we) begin
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_state   <= S_WR;
            end else begin
              r_arvalid <= 1'b1;
              r_state   <= S_RD;
            end
          end
        end
        S_WR: begin
          if (r_awvalid && i_awready) r_awvalid <= 1'b0;
          if (r_wvalid && i_wready)   r_wvalid  <= 1'b0;
          if (w_aw_done && w_w_done) begin
            r_bready <= 1'b1;
            r_state  <= S_WAIT_B;
          end
        end
        S_WAIT_B: begin
          if (i_bvalid) begin
            r_bready <= 1'b0;
            r_rvalid <= 1'b1;
            r_err    <= (i_bresp != 2'b00);
            r_state  <= S_IDLE;
          end
        end
        S_RD: begin
          if (i_arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= S_WAIT_R;
          end
        end
        S_WAIT_R: begin
          if (i_rvalid) begin
            r_rready <= 1'b0;
            r_rvalid <= 1'b1;
            r_rdata  <= i_rdata;
            r_err    <= (i_rresp != 2'b00);
            r_state  <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // single-beat, full-width INCR bursts
  assign o_awid    = AXI_ID;
  assign o_awaddr  = {r_addr, 3'b000};
  assign o_awlen   = 8'd0;
  assign o_awsize  = 3'd3;
  assign o_awburst = 2'b01;
  assign o_awvalid = r_awvalid;

  assign o_wdata  = r_wdata;
  assign o_wstrb  = r_be;
  assign o_wlast  = 1'b1;
  assign o_wvalid = r_wvalid;

  assign o_bready = r_bready;

  assign o_arid    = AXI_ID;
  assign o_araddr  = {r_addr, 3'b000};
  assign o_arlen   = 8'd0;
  assign o_arsize  = 3'd3;
  assign o_arburst = 2'b01;
  assign o_arvalid = r_arvalid;

  assign o_rready = r_rready;

  assign o_rvalid = r_rvalid;
  assign o_rdata  = r_rdata;
  assign o_err    = r_err;

endmodule

// File: tb/tb_mem2axi_master.sv
// tb_mem2axi_master
//   Directed bench for mem2axi_master. A small AXI slave model answers each
//   channel after a configurable number of wait cycles with configurable
//   response codes and read data. Inputs change on the falling edge and
//   outputs are sampled 1 time unit later.
module tb_mem2axi_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req;
  logic        i_we;
  logic [31:0] i_addr;
  logic [7:0]  i_be;
  logic [63:0] i_wdata;
  logic        o_gnt;
  logic        o_rvalid;
  logic [63:0] o_rdata;
  logic        o_err;
  logic [0:0]  o_awid;
  logic [31:0] o_awaddr;
  logic [7:0]  o_awlen;
  logic [2:0]  o_awsize;
  logic [1:0]  o_awburst;
  logic        o_awvalid;
  logic        i_awready;
  logic [63:0] o_wdata;
  logic [7:0]  o_wstrb;
  logic        o_wlast;
  logic        o_wvalid;
  logic        i_wready;
  logic [0:0]  i_bid;
  logic [1:0]  i_bresp;
  logic        i_bvalid;
  logic        o_bready;
  logic [0:0]  o_arid;
  logic [31:0] o_araddr;
  logic [7:0]  o_arlen;
  logic [2:0]  o_arsize;
  logic [1:0]  o_arburst;
  logic        o_arvalid;
  logic        i_arready;
  logic [0:0]  i_rid;
  logic [63:0] i_rdata;
  logic [1:0]  i_rresp;
  logic        i_rlast;
  logic        i_rvalid;
  logic        o_rready;

  int checks   = 0;
  int failures = 0;

  // slave model configuration
  int          aw_delay = 0;
  int          w_delay  = 0;
  int          b_delay  = 0;
  int          ar_delay = 0;
  int          r_delay  = 0;
  logic [1:0]  cfg_bresp = 2'b00;
  logic [1:0]  cfg_rresp = 2'b00;
  logic [63:0] cfg_rdata = 64'h0;

  int aw_cnt = 0;
  int w_cnt  = 0;
  int b_cnt  = 0;
  int ar_cnt = 0;
  int r_cnt  = 0;

  always #5 clk = ~clk;

  mem2axi_master dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_we(i_we), .i_addr(i_addr), .i_be(i_be), .i_wdata(i_wdata),
    .o_gnt(o_gnt), .o_rvalid(o_rvalid), .o_rdata(o_rdata), .o_err(o_err),
    .o_awid(o_awid), .o_awaddr(o_awaddr), .o_awlen(o_awlen), .o_awsize(o_awsize),
    .o_awburst(o_awburst), .o_awvalid(o_awvalid), .i_awready(i_awready),
    .o_wdata(o_wdata), .o_wstrb(o_wstrb), .o_wlast(o_wlast), .o_wvalid(o_wvalid),
    .i_wready(i_wready),
    .i_bid(i_bid), .i_bresp(i_bresp), .i_bvalid(i_bvalid), .o_bready(o_bready),
    .o_arid(o_arid), .o_araddr(o_araddr), .o_arlen(o_arlen), .o_arsize(o_arsize),
    .o_arburst(o_arburst), .o_arvalid(o_arvalid), .i_arready(i_arready),
    .i_rid(i_rid), .i_rdata(i_rdata), .i_rresp(i_rresp), .i_rlast(i_rlast),
    .i_rvalid(i_rvalid), .o_rready(o_rready)
  );

  // slave model: each ready/valid answers after <delay> cycles of waiting
  assign i_awready = o_awvalid && (aw_cnt >= aw_delay);
  assign i_wready  = o_wvalid  && (w_cnt  >= w_delay);
  assign i_bvalid  = o_bready  && (b_cnt  >= b_delay);
  assign i_arready = o_arvalid && (ar_cnt >= ar_delay);
  assign i_rvalid  = o_rready  && (r_cnt  >= r_delay);
  assign i_bresp   = cfg_bresp;
  assign i_rresp   = cfg_rresp;
  assign i_rdata   = cfg_rdata;
  assign i_bid     = 1'b1;
  assign i_rid     = 1'b1;
  assign i_rlast   = 1'b1;

  always @(posedge clk) begin
    aw_cnt <= (!o_awvalid || i_awready) ? 0 : aw_cnt + 1;
    w_cnt  <= (!o_wvalid  || i_wready)  ? 0 : w_cnt + 1;
    b_cnt  <= (!o_bready  || i_bvalid)  ? 0 : b_cnt + 1;
    ar_cnt <= (!o_arvalid || i_arready) ? 0 : ar_cnt + 1;
    r_cnt  <= (!o_rready  || i_rvalid)  ? 0 : r_cnt + 1;
  end

  // Present a request on the next falling edge and report the grant.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [7:0] be,
                       input logic [63:0] data, output logic g);
    @(negedge clk);
    i_req   = 1'b1;
    i_we    = we;
    i_addr  = addr;
    i_be    = be;
    i_wdata = data;
    #1;
    g = o_gnt;
  endtask

  // Run n cycles with i_req low, collecting channel activity.
  // first_rv is the 1-based cycle index of the first o_rvalid (0 = none).
  task automatic monitor(input int n, input logic [31:0] exp_addr,
                         output int aw_n, output int w_n, output int ar_n,
                         output int rv_n, output int first_rv,
                         output logic [63:0] rd, output logic er,
                         output logic addr_moved);
    aw_n = 0; w_n = 0; ar_n = 0; rv_n = 0; first_rv = 0;
    rd = '0; er = 1'b0; addr_moved = 1'b0;
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      i_req = 1'b0;
      #1;
      if (o_awvalid) begin
        aw_n++;
        if (o_awaddr !== exp_addr) addr_moved = 1'b1;
      end
      if (o_wvalid) w_n++;
      if (o_arvalid) ar_n++;
      if (o_rvalid) begin
        rv_n++;
        if (first_rv == 0) first_rv = c;
        rd = o_rdata;
        er = o_err;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; i_req = 1'b1; i_we = 1'b0; i_addr = 32'h10; i_be = 8'h0; i_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    checks++;
    if (o_gnt !== 1'b0) begin failures++; $display("FAIL rst_gnt: got %0b want 0", o_gnt); end
    checks++;
    if ({o_awvalid, o_wvalid, o_arvalid, o_bready, o_rready} !== 5'b0) begin
      failures++;
      $display("FAIL rst_handshake: got %b want 00000",
               {o_awvalid, o_wvalid, o_arvalid, o_bready, o_rready});
    end
    checks++;
    if ({o_rvalid, o_err} !== 2'b00) begin
      failures++; $display("FAIL rst_rvalid_err: got %b want 00", {o_rvalid, o_err});
    end
    checks++;
    if (o_rdata !== 64'h0) begin failures++; $display("FAIL rst_rdata: got %h want 0", o_rdata); end
    rst = 1'b0; i_req = 1'b0;
    $display("tx reset released");
  endtask

  task automatic test_write_basic();
    logic g, er, moved;
    logic [63:0] rd;
    int aw_n, w_n, ar_n, rv_n, frv;
    issue(1'b1, 32'h8000_0004, 8'hFF, 64'h1122334455667788, g);
    checks++;
    if (g !== 1'b1) begin failures++; $display("FAIL wr_gnt: got %0b want 1", g); end
    @(negedge clk); i_req = 1'b0; #1;
    checks++;
    if ({o_awvalid, o_wvalid} !== 2'b11) begin
      failures++; $display("FAIL wr_valids_t1: got %b want 11", {o_awvalid, o_wvalid});
    end
    checks++;
    if (o_awaddr !== 32'h8000_0000) begin
      failures++; $display("FAIL wr_awaddr: got %h want 80000000", o_awaddr);
    end
    checks++;
    if ({o_wstrb, o_wdata} !== {8'hFF, 64'h1122334455667788}) begin
      failures++; $display("FAIL wr_wdata: got %h/%h want ff/1122334455667788", o_wstrb, o_wdata);
    end
    checks++;
    if ({o_awid, o_awlen, o_awsize, o_awburst, o_wlast} !== {1'b0, 8'd0, 3'd3, 2'b01, 1'b1}) begin
      failures++;
      $display("FAIL wr_consts: got id=%0d len=%0d size=%0d burst=%0d last=%0b want 0/0/3/1/1",
               o_awid, o_awlen, o_awsize, o_awburst, o_wlast);
    end
    monitor(6, 32'h8000_0000, aw_n, w_n, ar_n, rv_n, frv, rd, er, moved);
    checks++;
    if (rv_n !== 1 || frv !== 2) begin
      failures++; $display("FAIL wr_latency: got pulses=%0d at T+%0d want 1 at T+3", rv_n, frv + 1);
    end
    checks++;
    if (er !== 1'b0) begin failures++; $display("FAIL wr_err: got %0b want 0", er); end
    $display("tx write addr=80000004 pulses=%0d err=%0b", rv_n, er);
  endtask

  task automatic test_write_aw_delay();
    logic g, er, moved;
    logic [63:0] rd;
    int aw_n, w_n, ar_n, rv_n, frv;
    aw_delay = 4;
    issue(1'b1, 32'h0000_1238, 8'h0F, 64'hA5A5_0000_5A5A_FFFF, g);
    checks++;
    if (g !== 1'b1) begin failures++; $display("FAIL awdly_gnt: got %0b want 1", g); end
    monitor(15, 32'h0000_1238, aw_n, w_n, ar_n, rv_n, frv, rd, er, moved);
    checks++;
    if (aw_n !== 5 || w_n !== 1) begin
      failures++; $display("FAIL awdly_valid_cycles: got aw=%0d w=%0d want aw=5 w=1", aw_n, w_n);
    end
    checks++;
    if (moved !== 1'b0) begin failures++; $display("FAIL awdly_addr_stable: got moved=1 want 0"); end
    checks++;
    if (rv_n !== 1 || er !== 1'b0) begin
      failures++; $display("FAIL awdly_completion: got pulses=%0d err=%0b want 1/0", rv_n, er);
    end
    aw_delay = 0;
    $display("tx write addr=00001238 aw_cycles=%0d w_cycles=%0d pulses=%0d", aw_n, w_n, rv_n);
  endtask

  task automatic test_read_wait();
    logic g, er, moved;
    logic [63:0] rd;
    int aw_n, w_n, ar_n, rv_n, frv;
    r_delay = 6; cfg_rdata = 64'hDEADBEEFCAFEF00D;
    issue(1'b0, 32'h0000_0047, 8'h00, 64'h0, g);
    checks++;
    if (g !== 1'b1) begin failures++; $display("FAIL rd_gnt: got %0b want 1", g); end
    @(negedge clk); i_req = 1'b0; #1;
    checks++;
    if ({o_arvalid, o_araddr} !== {1'b1, 32'h0000_0040}) begin
      failures++; $display("FAIL rd_ar: got valid=%0b addr=%h want 1/00000040", o_arvalid, o_araddr);
    end
    checks++;
    if ({o_arid, o_arlen, o_arsize, o_arburst} !== {1'b0, 8'd0, 3'd3, 2'b01}) begin
      failures++;
      $display("FAIL rd_consts: got id=%0d len=%0d size=%0d burst=%0d want 0/0/3/1",
               o_arid, o_arlen, o_arsize, o_arburst);
    end
    monitor(15, 32'h0, aw_n, w_n, ar_n, rv_n, frv, rd, er, moved);
    cfg_rdata = 64'h0;
    checks++;
    if (rv_n !== 1 || frv !== 8) begin
      failures++; $display("FAIL rd_pulse: got pulses=%0d at c=%0d want 1 at c=8", rv_n, frv);
    end
    checks++;
    if (rd !== 64'hDEADBEEFCAFEF00D || er !== 1'b0) begin
      failures++; $display("FAIL rd_data: got %h err=%0b want deadbeefcafef00d/0", rd, er);
    end
    checks++;
    if (o_rdata !== 64'hDEADBEEFCAFEF00D) begin
      failures++; $display("FAIL rd_hold: got %h want deadbeefcafef00d", o_rdata);
    end
    r_delay = 0;
    $display("tx read addr=00000040 data=%h pulses=%0d", rd, rv_n);
  endtask

  task automatic test_errors();
    logic g, er, moved;
    logic [63:0] rd;
    int aw_n, w_n, ar_n, rv_n, frv;
    cfg_rresp = 2'b10; cfg_rdata = 64'h0000_1111_2222_3333;
    issue(1'b0, 32'h0000_0100, 8'h00, 64'h0, g);
    monitor(6, 32'h0, aw_n, w_n, ar_n, rv_n, frv, rd, er, moved);
    checks++;
    if (rv_n !== 1 || er !== 1'b1) begin
      failures++; $display("FAIL rd_slverr: got pulses=%0d err=%0b want 1/1", rv_n, er);
    end
    $display("tx read slverr pulses=%0d err=%0b", rv_n, er);
    cfg_rresp = 2'b00;
    cfg_bresp = 2'b11;
    issue(1'b1, 32'h0000_0200, 8'h01, 64'h77, g);
    monitor(6, 32'h0000_0200, aw_n, w_n, ar_n, rv_n, frv, rd, er, moved);
    checks++;
    if (rv_n !== 1 || er !== 1'b1) begin
      failures++; $display("FAIL wr_decerr: got pulses=%0d err=%0b want 1/1", rv_n, er);
    end
    $display("tx write decerr pulses=%0d err=%0b", rv_n, er);
    cfg_bresp = 2'b00;
  endtask

  task automatic test_back_to_back();
    logic g, er, moved;
    logic [63:0] rd;
    int aw_n, w_n, ar_n, rv_n, frv;
    int gnts = 0, pulses = 0, coincide = 0, first_co = -1;
    logic busy_grant = 1'b0;
    cfg_rdata = 64'h0BAD_F00D_1234_5678;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      i_req = 1'b1; i_we = 1'b0; i_addr = 32'h0000_0300;
      #1;
      if (o_gnt) gnts++;
      if (o_rvalid) pulses++;
      if (o_gnt && o_rvalid) begin
        coincide++;
        if (first_co < 0) first_co = c;
      end
      if (o_gnt && (o_arvalid || o_rready || o_awvalid || o_wvalid || o_bready)) busy_grant = 1'b1;
    end
    monitor(5, 32'h0, aw_n, w_n, ar_n, rv_n, frv, rd, er, moved);
    checks++;
    if (gnts !== 4 || pulses !== 3) begin
      failures++; $display("FAIL b2b_counts: got gnts=%0d pulses=%0d want 4/3", gnts, pulses);
    end
    checks++;
    if (coincide !== 3 || first_co !== 3) begin
      failures++;
      $display("FAIL b2b_gnt_in_rvalid: got %0d first at %0d want 3 first at 3", coincide, first_co);
    end
    checks++;
    if (busy_grant !== 1'b0) begin failures++; $display("FAIL b2b_outstanding: got 1 want 0"); end
    checks++;
    if (rv_n !== 1 || rd !== 64'h0BAD_F00D_1234_5678) begin
      failures++; $display("FAIL b2b_drain: got pulses=%0d data=%h want 1/0badf00d12345678", rv_n, rd);
    end
    $display("tx back_to_back grants=%0d pulses=%0d", gnts, pulses + rv_n);
  endtask

  task automatic test_reset_mid();
    logic g, er, moved;
    logic [63:0] rd;
    int aw_n, w_n, ar_n, rv_n, frv;
    b_delay = 10;
    issue(1'b1, 32'h0000_0400, 8'hFF, 64'h1, g);
    @(negedge clk); i_req = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (o_bready !== 1'b1) begin failures++; $display("FAIL rstmid_in_wait_b: got %0b want 1", o_bready); end
    rst = 1'b1; i_req = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (o_gnt !== 1'b0) begin failures++; $display("FAIL rstmid_gnt: got %0b want 0", o_gnt); end
    checks++;
    if ({o_awvalid, o_wvalid, o_arvalid, o_bready, o_rready, o_rvalid} !== 6'b0) begin
      failures++;
      $display("FAIL rstmid_cleared: got %b want 000000",
               {o_awvalid, o_wvalid, o_arvalid, o_bready, o_rready, o_rvalid});
    end
    rst = 1'b0; i_req = 1'b0; b_delay = 0;
    monitor(6, 32'h0, aw_n, w_n, ar_n, rv_n, frv, rd, er, moved);
    checks++;
    if (rv_n !== 0) begin failures++; $display("FAIL rstmid_no_pulse: got %0d want 0", rv_n); end
    cfg_rdata = 64'h0123456789ABCDEF;
    issue(1'b0, 32'h0000_0500, 8'h00, 64'h0, g);
    checks++;
    if (g !== 1'b1) begin failures++; $display("FAIL rstmid_read_gnt: got %0b want 1", g); end
    monitor(6, 32'h0, aw_n, w_n, ar_n, rv_n, frv, rd, er, moved);
    checks++;
    if (rv_n !== 1 || frv !== 3 || rd !== 64'h0123456789ABCDEF || er !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_read: got pulses=%0d c=%0d data=%h err=%0b want 1/3/0123456789abcdef/0",
               rv_n, frv, rd, er);
    end
    $display("tx read after reset data=%h pulses=%0d", rd, rv_n);
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_write_aw_delay();
    test_read_wait();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
